// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: FSM state encoding
// and default parameter values.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam int REG_AW_DEF   = 5;
    localparam int WAIT_MAX_DEF = 16;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard inputs, register enables and status/counter outputs
// exchanged between the datapath side (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if import pipe_ctrl_pkg::*; #(
    parameter int REG_AW = REG_AW_DEF
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              mem_req;
    logic              mem_ready;

    logic              pc_load;
    logic              ifid_load;
    logic              idex_load;
    logic              exmem_load;
    logic              memwb_load;
    logic              ifid_flush;
    logic              idex_flush;
    logic              halted;
    logic [31:0]       stall_cycles;
    logic [31:0]       flush_events;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
               ifid_flush, idex_flush, halted, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
               ifid_flush, idex_flush, halted, stall_cycles, flush_events
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: flags when the ID instruction reads a
// register that the load currently in EX is about to write. x0 never
// creates a dependency.
module hazard_detect import pipe_ctrl_pkg::*; #(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              load_use
);

    logic rd_live;
    logic hit_rs1;
    logic hit_rs2;

    // Match each used source against the EX destination
    always_comb begin
        rd_live  = ex_mem_read && (ex_rd != '0);
        hit_rs1  = uses_rs1 && (rs1 == ex_rd);
        hit_rs2  = uses_rs2 && (rs2 == ex_rd);
        load_use = rd_live && (hit_rs1 || hit_rs2);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: per-cycle load/flush enables for PC and stage
// registers, memory-wait freeze with a watchdog that halts the core.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined;
// otherwise stall_cycles/flush_events are tied to zero.
module pipeline_ctrl import pipe_ctrl_pkg::*; #(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int REG_AW   = REG_AW_DEF
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WAIT_MAX) + 1;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             load_use;
    logic             freeze;
    logic             fire;
    logic             pc_load;
    logic             ifid_load;
    logic             idex_load;
    logic             exmem_load;
    logic             memwb_load;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .rs1         (bus.id_rs1),
        .rs2         (bus.id_rs2),
        .uses_rs1    (bus.id_uses_rs1),
        .uses_rs2    (bus.id_uses_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .load_use    (load_use)
    );

    assign freeze = bus.mem_req && !bus.mem_ready;

    // State and watchdog count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    // Next state, watchdog count and prioritised Mealy enables
    always_comb begin
        next_state = state;
        next_cnt   = '0;
        pc_load    = 1'b0;
        ifid_load  = 1'b0;
        idex_load  = 1'b0;
        exmem_load = 1'b0;
        memwb_load = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        fire       = 1'b0;
        if (rst) begin
            next_state = RUN;
        end else if (state == HALT) begin
            halted = 1'b1;
        end else if (freeze) begin
            // Whole pipe holds; branch/load-use are re-evaluated once memory answers
            next_cnt   = wait_cnt + CNT_W'(1);
            next_state = (wait_cnt == CNT_W'(WAIT_MAX - 1)) ? HALT : MEM_WAIT;
        end else begin
            next_state = RUN;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
            idex_load  = 1'b1;
            if (bus.ex_branch_taken) begin
                // Squashing ID makes any load-use stall moot
                pc_load    = 1'b1;
                ifid_load  = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                fire       = 1'b1;
            end else if (load_use) begin
                // Hold PC/IF-ID, inject one bubble into EX
                idex_flush = 1'b1;
                fire       = 1'b1;
            end else begin
                pc_load   = 1'b1;
                ifid_load = 1'b1;
            end
        end
    end

    assign bus.pc_load    = pc_load;
    assign bus.ifid_load  = ifid_load;
    assign bus.idex_load  = idex_load;
    assign bus.exmem_load = exmem_load;
    assign bus.memwb_load = memwb_load;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_flush = idex_flush;
    assign bus.halted     = halted;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Performance counters: PC-hold cycles and branch/bubble flush events
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_load) stall_cnt <= stall_cnt + 32'd1;
            if (fire)     flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_events = flush_cnt;
`else
    logic unused_fire;
    assign unused_fire      = fire;
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl (WAIT_MAX=4): directed vector table with
// explicit expectations, then randomized traffic against a reference model.
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int WM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.REG_AW(5)) bus();

    pipeline_ctrl #(.WAIT_MAX(WM), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // exp = {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halted}
    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: halted flag, consecutive frozen cycles, counters
    bit          m_halted = 1'b0;
    int          m_frozen = 0;
    int unsigned m_stall  = 0;
    int unsigned m_flush  = 0;

    vec_t tab[$];

    function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic [4:0] rd, logic mr,
                                logic br, logic req, logic rdy, logic [7:0] exp);
        vec_t v;
        v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.mr = mr; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    function automatic bit is_load_use(vec_t v);
        return v.mr && (v.rd != 0) &&
               ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    endfunction

    function automatic logic [7:0] model_out(vec_t v);
        if (v.rst)             return 8'b0000_0000;
        if (m_halted)          return 8'b0000_0001;
        if (v.req && !v.rdy)   return 8'b0000_0000;
        if (v.br)              return 8'b1111_1110;
        if (is_load_use(v))    return 8'b0011_1010;
        return 8'b1111_1000;
    endfunction

    task automatic model_update(vec_t v);
        logic [7:0] o;
        bit fz;
        o  = model_out(v);
        fz = v.req && !v.rdy;
        if (v.rst) begin
            m_halted = 1'b0;
            m_frozen = 0;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            if (!o[7]) m_stall++;
            if (!m_halted && !fz && (v.br || is_load_use(v))) m_flush++;
            if (!m_halted) begin
                if (fz) begin
                    m_frozen++;
                    if (m_frozen == WM) m_halted = 1'b1;
                end else begin
                    m_frozen = 0;
                end
            end
        end
    endtask

    task automatic step(vec_t v, bit use_tab, string name);
        logic [7:0]  got;
        logic [7:0]  exp;
        logic [31:0] exp_s;
        logic [31:0] exp_f;
        @(negedge clk);
        rst                 = v.rst;
        bus.id_rs1          = v.rs1;
        bus.id_rs2          = v.rs2;
        bus.id_uses_rs1     = v.u1;
        bus.id_uses_rs2     = v.u2;
        bus.ex_rd           = v.rd;
        bus.ex_mem_read     = v.mr;
        bus.ex_branch_taken = v.br;
        bus.mem_req         = v.req;
        bus.mem_ready       = v.rdy;
        #1;
        got = {bus.pc_load, bus.ifid_load, bus.idex_load, bus.exmem_load,
               bus.memwb_load, bus.ifid_flush, bus.idex_flush, bus.halted};
        exp = use_tab ? v.exp : model_out(v);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: enables got %b want %b", name, got, exp);
        end
`ifdef PIPE_CTRL_PERF_EN
        exp_s = m_stall;
        exp_f = m_flush;
`else
        exp_s = 32'd0;
        exp_f = 32'd0;
`endif
        n_vec++;
        if (bus.stall_cycles !== exp_s || bus.flush_events !== exp_f) begin
            n_err++;
            $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     name, bus.stall_cycles, bus.flush_events, exp_s, exp_f);
        end
        @(posedge clk);
        model_update(v);
    endtask

    initial begin
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 1'b0;
        bus.id_uses_rs2 = 1'b0; bus.ex_rd = '0; bus.ex_mem_read = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;

        //                r  rs1 rs2 u1 u2 rd mr br req rdy exp
        tab.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000)); // reset with wait pending
        tab.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000));
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 8'b1111_1000)); // RUN after reset
        tab.push_back(mk(0, 1,  5,  0, 1, 5, 1, 0, 0, 0, 8'b0011_1010)); // load-use via rs2
        tab.push_back(mk(0, 1,  5,  0, 1, 5, 0, 0, 0, 0, 8'b1111_1000)); // load moved on
        tab.push_back(mk(0, 0,  0,  1, 1, 0, 1, 0, 0, 0, 8'b1111_1000)); // x0 never stalls
        tab.push_back(mk(0, 7,  7,  0, 0, 7, 1, 0, 0, 0, 8'b1111_1000)); // sources unused
        tab.push_back(mk(0, 7,  2,  1, 0, 7, 1, 0, 0, 0, 8'b0011_1010)); // load-use via rs1
        tab.push_back(mk(0, 1,  5,  0, 1, 5, 1, 1, 0, 0, 8'b1111_1110)); // branch over load-use
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000)); // mem wait x3
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000));
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000));
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 1, 8'b1111_1000)); // ready cycle
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 1, 1, 0, 8'b0000_0000)); // freeze + branch
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 1, 1, 1, 8'b1111_1110)); // branch on ready
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000)); // watchdog: 4 frozen
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000));
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000));
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000));
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 1, 8'b0000_0001)); // halted, ready ignored
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 1, 0, 0, 8'b0000_0001)); // sticky
        tab.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 8'b0000_0000)); // reset out of HALT
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 8'b1111_1000));
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000)); // 3 freezes: no halt
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000));
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 8'b0000_0000));
        tab.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 8'b1111_1000)); // req dropped

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i], 1'b1, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 600; i++) begin
            vec_t v;
            bit   slow;
            slow  = ((i / 40) % 3) == 1;
            v.rst = ($urandom_range(0, 39) == 0);
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.u1  = 1'($urandom);
            v.u2  = 1'($urandom);
            v.mr  = 1'($urandom);
            v.br  = ($urandom_range(0, 3) == 0);
            v.req = slow ? 1'b1 : 1'($urandom);
            v.rdy = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            v.exp = 8'h00;
            step(v, 1'b0, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
